// File: rtl/booth_ppg_seq.sv
// Sequential radix-8 Booth partial-product generator.
// Accepts an unsigned X/Y pair, precomputes the X multiples, then emits one
// partial product per digit (ones'-complement + neg correction bit) with a
// valid/ready handshake on the output side.
module booth_ppg_seq #(
  parameter int unsigned W = 24,
  localparam int unsigned NDIG = W / 3 + 1,
  localparam int unsigned IW = $clog2(NDIG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x_i,
  input  logic [W-1:0]  y_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W+2:0]  pp_o,
  output logic          neg_o,
  output logic [IW-1:0] idx_o,
  output logic          last_o
);

  // Y is stored with an appended y[-1] = 0 and zero-extended to 3*NDIG bits.
  localparam int unsigned YW = 3 * NDIG + 1;
  localparam int unsigned MW = W + 2;

  typedef enum logic [1:0] {StIdle, StPrecomp, StEmit} state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [W-1:0]  x_q;
  logic [YW-1:0] y_q;
  logic [MW-1:0] x1_q, x2_q, x3_q, x4_q;

  logic          accept;
  logic          last_digit;
  logic [YW-1:0] y_sh;
  logic [3:0]    trip;
  logic [MW-1:0] mag;
  logic          neg_raw;

  // in_ready_q is only ever high in StIdle, so it doubles as the state qualifier.
  assign accept     = in_valid && in_ready_q;
  assign last_digit = (idx_q == IW'(NDIG - 1));

  // Control FSM: state, digit index and the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StPrecomp;
            in_ready_q <= 1'b0;
          end
        end
        StPrecomp: begin
          idx_q       <= '0;
          out_valid_q <= 1'b1;
          state_q     <= StEmit;
        end
        StEmit: begin
          if (out_ready) begin
            if (last_digit) begin
              state_q     <= StIdle;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              idx_q       <= '0;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          idx_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Operand capture, only on an accepted handshake (a reset edge wins).
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      x_q <= x_i;
      y_q <= {{(YW - W - 1){1'b0}}, y_i, 1'b0};
    end
  end

  // Multiples of X, computed once per operation during the precompute cycle.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == StPrecomp) begin
      x1_q <= {2'b00, x_q};
      x2_q <= {1'b0, x_q, 1'b0};
      x4_q <= {x_q, 2'b00};
      x3_q <= {1'b0, x_q, 1'b0} + {2'b00, x_q};
    end
  end

  // Booth digit decode from registered Y and index; outputs zero when not valid.
  always_comb begin
    y_sh    = y_q >> (3 * idx_q);
    trip    = y_sh[3:0];
    mag     = '0;
    // Pattern 1111 is digit zero and must not raise the correction bit.
    neg_raw = trip[3] && !(&trip[2:0]);
    unique case (trip)
      4'b0000, 4'b1111:                   mag = '0;
      4'b0001, 4'b0010, 4'b1101, 4'b1110: mag = x1_q;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: mag = x2_q;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: mag = x3_q;
      4'b0111, 4'b1000:                   mag = x4_q;
      default:                            mag = '0;
    endcase

    pp_o  = '0;
    neg_o = 1'b0;
    if (out_valid_q) begin
      neg_o = neg_raw;
      pp_o  = neg_raw ? ~{1'b0, mag} : {1'b0, mag};
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign idx_o     = idx_q;
  assign last_o    = out_valid_q && last_digit;

endmodule

// File: doc/booth_ppg_seq.md
BOOTH_PPG_SEQ -- requirements
Module: booth_ppg_seq

Interface
REQ-001 SHALL have parameter W, default 24, meaning multiplicand and multiplier width in bits (unsigned operands, W >= 3).
REQ-002 SHALL have derived localparams:
- NDIG = W/3 + 1 (integer division): the radix-8 digit count.
- IW = $clog2(NDIG): the digit index width.
REQ-003 SHALL use one clock and a synchronous, active-low reset, with ports listed clock first:
- clk  in  1  clock, all state updates on its rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept an operand pair
- x_i  in  W  multiplicand X
- y_i  in  W  multiplier Y
- out_valid  out  1  partial product presented
- out_ready  in  1  consumer accepts the partial product
- pp_o  out  W+3  partial product, ones'-complemented when negative
- neg_o  out  1  +1 correction bit for pp_o
- idx_o  out  IW  digit index i of the current partial product
- last_o  out  1  high when idx_o == NDIG-1

Function
REQ-004 SHALL implement a three-state FSM: IDLE, PRECOMP, EMIT.
REQ-005 IDLE SHALL behave as follows:
- in_ready = 1 and out_valid = 0.
- On in_valid && in_ready, register X and Y (Y zero-extended to 3*NDIG bits), then go to PRECOMP.
REQ-006 PRECOMP SHALL last exactly one cycle:
- Register the multiples X1 = {2'b0,X}, X2 = {1'b0,X,1'b0}, X4 = {X,2'b0} and X3 = X2 + X1, all W+2 bits; X3 never overflows.
- Clear the digit index to 0.
- Go to EMIT.
REQ-007 EMIT SHALL assert out_valid = 1 and present digit idx_o.
- On out_ready && !last_o, increment the index.
- On out_ready && last_o, return to IDLE.
REQ-008 Digit i SHALL be d = -4*y[3i+2] + 2*y[3i+1] + y[3i] + y[3i-1], with y[-1] = 0 and bits above W-1 equal to 0; d is in the range -4..+4.
REQ-009 The magnitude SHALL be selected from the multiples: mag = 0, X1, X2, X3 or X4 for |d| = 0, 1, 2, 3 or 4.
REQ-010 The outputs SHALL be set from d and mag:
- neg_o = 1 iff d < 0; d = 0 always gives neg_o = 0 (this includes Booth pattern 1111).
- pp_o = neg_o ? ~{1'b0,mag} : {1'b0,mag}.
REQ-011 Arithmetic invariant: signed(pp_o) + neg_o SHALL equal d*X, and the sum over i of (signed(pp_o) + neg_o)*8^i SHALL equal X*Y exactly.
REQ-012 Latency SHALL be fixed: for an input handshake in cycle t, digit 0 appears with out_valid = 1 in cycle t+2.
- With out_ready held high, one digit is emitted per cycle, so NDIG cycles in EMIT.
- in_ready returns high in the cycle after the last-digit handshake.
REQ-013 While out_valid && !out_ready, pp_o, neg_o, idx_o and last_o SHALL hold stable.
REQ-014 in_ready SHALL be 0 in PRECOMP and EMIT; in_valid in those states is ignored and x_i/y_i are not sampled.
REQ-015 All outputs SHALL be registered or decoded only from registered state; there is no combinational path from in_valid, x_i, y_i or out_ready to any output.
REQ-016 The X and Y operand registers SHALL change only on an accepted input handshake.

Reset
REQ-017 On a clk edge with rst_n = 0, the block SHALL set:
- state = IDLE and digit index = 0;
- in_ready = 1 after reset release, out_valid = 0;
- pp_o = 0, neg_o = 0, idx_o = 0, last_o = 0.
REQ-018 Reset asserted during PRECOMP or EMIT SHALL abandon the operation in that same edge.
- No further digits of the abandoned operation are emitted.
- The next accepted operand pair starts at idx_o = 0.
REQ-019 Reset SHALL take priority over any simultaneous handshake.

Verification
REQ-020 All scenarios use W = 24 (NDIG = 9).
- Basic: x = 5, y = 7 -> idx 0: neg_o = 1, pp_o = ~27'd5; idx 1: neg_o = 0, pp_o = 5; idx 2..8: pp_o = 0, neg_o = 0; last_o high only at idx 8.
- 3X path: x = 0xFFFFFF, y = 3 -> idx 0: pp_o = 0x2FFFFFD, neg_o = 0; idx 1..8: zero.
- Top digit: x = 1, y = 0xFFFFFF -> idx 0: neg_o = 1, pp_o = ~27'd1; idx 1..7: pp_o = 0, neg_o = 0 (pattern 1111); idx 8: pp_o = 1, neg_o = 0; weighted sum = 0xFFFFFF.
- Backpressure: hold out_ready low for 3 cycles at idx 0, with in_valid kept high throughout -> outputs stay stable, in_ready = 0, and there is no second capture.
- Reset mid-EMIT: pull rst_n low while idx_o = 4 -> next cycle out_valid = 0 and in_ready = 1; the next operation starts at idx 0 with correct values.
- Random: at least 10k random x, y pairs with random out_ready -> the REQ-011 sum equals x*y, and the per-operation handshake latency matches REQ-012.
